rom_arbiter: RTL and testbench

- Two-requester arbiter and access sequencer for the shared 16-bit program ROM (combinational read: addr, en -> Q).
- Shares the single ROM port between the instruction-fetch unit (port F) and the data-load path (port D).
- Uses round-robin priority and a req/ack handshake, with a configurable access wait so slower memories can replace the ROM later.
- Sits between the core's fetch/load logic and the memory block.

---
 rtl/rom_arbiter.sv | 109 ++++++++++
 tb/tb_rom_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Round-robin arbiter that shares one combinational-read ROM port between the
// instruction-fetch requester (F) and the data-load requester (D).
module rom_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_q,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    // Handshake: a requester raises req with a stable addr and keeps both until
    // it sees a one-cycle ack; rdata is valid from that ack cycle onward. req must
    // be dropped in the cycle after ack, or IDLE treats it as a fresh request.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t     state;
    state_t     state_nxt;
    logic       owner;
    logic       last_grant;
    logic [3:0] wait_cnt;
    logic       grant_f;
    logic       grant_d;

    // F wins a tie only when D held the ROM last, which gives strict alternation.
    always_comb begin
        grant_f = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            grant_f = f_req && (!d_req || (last_grant == PORT_D));
            grant_d = d_req && !grant_f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_f || grant_d) state_nxt = ACCESS;
            ACCESS:  if (wait_cnt == 4'd0)   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr   <= '0;
            owner      <= PORT_F;
            last_grant <= PORT_D;
            wait_cnt   <= 4'd0;
            f_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_f || grant_d) begin
                        rom_addr <= grant_f ? f_addr : d_addr;
                        owner    <= grant_d ? PORT_D : PORT_F;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        if (owner == PORT_F) f_rdata <= rom_q;
                        else                 d_rdata <= rom_q;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP:    last_grant <= owner;
                default: ;
            endcase
        end
    end

    // Outputs decode the registered state, so they are glitch-free and clear on reset.
    assign rom_en    = (state == ACCESS);
    assign busy      = (state == ACCESS) || (state == RESP);
    assign f_ack     = (state == RESP) && (owner == PORT_F);
    assign d_ack     = (state == RESP) && (owner == PORT_D);
    assign state_dbg = state;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: one instance with no wait states, one with three.
module tb_rom_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance with WAIT_CYCLES = 0
    logic        rst0, f_req0, d_req0, f_ack0, d_ack0, rom_en0, busy0;
    logic [15:0] f_addr0, d_addr0, f_rdata0, d_rdata0, rom_addr0, rom_q0;
    logic [1:0]  state0;
    // Instance with WAIT_CYCLES = 3
    logic        rst3, f_req3, d_req3, f_ack3, d_ack3, rom_en3, busy3;
    logic [15:0] f_addr3, d_addr3, f_rdata3, d_rdata3, rom_addr3, rom_q3;
    logic [1:0]  state3;

    // ROM model: inverted address when enabled, zero otherwise
    assign rom_q0 = rom_en0 ? ~rom_addr0 : 16'h0000;
    assign rom_q3 = rom_en3 ? ~rom_addr3 : 16'h0000;

    rom_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0),
        .f_req(f_req0), .f_addr(f_addr0), .f_ack(f_ack0), .f_rdata(f_rdata0),
        .d_req(d_req0), .d_addr(d_addr0), .d_ack(d_ack0), .d_rdata(d_rdata0),
        .rom_addr(rom_addr0), .rom_en(rom_en0), .rom_q(rom_q0),
        .busy(busy0), .state_dbg(state0)
    );

    rom_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3),
        .f_req(f_req3), .f_addr(f_addr3), .f_ack(f_ack3), .f_rdata(f_rdata3),
        .d_req(d_req3), .d_addr(d_addr3), .d_ack(d_ack3), .d_rdata(d_rdata3),
        .rom_addr(rom_addr3), .rom_en(rom_en3), .rom_q(rom_q3),
        .busy(busy3), .state_dbg(state3)
    );

    task automatic do_reset();
        rst0 = 1'b1; rst3 = 1'b1;
        f_req0 = 1'b0; d_req0 = 1'b0; f_addr0 = '0; d_addr0 = '0;
        f_req3 = 1'b0; d_req3 = 1'b0; f_addr3 = '0; d_addr3 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0; rst3 = 1'b0;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst3 = 1'b1;
        f_req0 = 1'b1; d_req0 = 1'b1; f_req3 = 1'b1; d_req3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({f_ack0, d_ack0, rom_en0, busy0, state0} !== 6'b0 ||
            f_rdata0 !== 16'h0 || d_rdata0 !== 16'h0 || rom_addr0 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_w0: ack=%b%b en=%b busy=%b st=%0d fr=%h dr=%h ra=%h, required all zero",
                     f_ack0, d_ack0, rom_en0, busy0, state0, f_rdata0, d_rdata0, rom_addr0);
        end
        n_checks++;
        if ({f_ack3, d_ack3, rom_en3, busy3, state3} !== 6'b0 ||
            f_rdata3 !== 16'h0 || d_rdata3 !== 16'h0 || rom_addr3 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_w3: ack=%b%b en=%b busy=%b st=%0d fr=%h dr=%h ra=%h, required all zero",
                     f_ack3, d_ack3, rom_en3, busy3, state3, f_rdata3, d_rdata3, rom_addr3);
        end
        do_reset();
    endtask

    task automatic test_single_fetch();
        do_reset();
        f_req0 = 1'b1; f_addr0 = 16'h0002;
        @(negedge clk);   // IDLE cycle that sees the request
        n_checks++;
        if (busy0 !== 1'b0 || rom_en0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b en=%b, required 0 0", busy0, rom_en0);
        end
        @(negedge clk);   // ACCESS
        n_checks++;
        if ({rom_en0, busy0, f_ack0, d_ack0} !== 4'b1100 || rom_addr0 !== 16'h0002) begin
            n_fail++;
            $display("FAIL single_access: en/busy/fack/dack=%b%b%b%b addr=%h, required 1100 0002",
                     rom_en0, busy0, f_ack0, d_ack0, rom_addr0);
        end
        @(negedge clk);   // RESP
        n_checks++;
        if ({rom_en0, busy0, f_ack0, d_ack0} !== 4'b0110 || f_rdata0 !== 16'hFFFD) begin
            n_fail++;
            $display("FAIL single_resp: en/busy/fack/dack=%b%b%b%b rdata=%h, required 0110 FFFD",
                     rom_en0, busy0, f_ack0, d_ack0, f_rdata0);
        end
        f_req0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy0, f_ack0, d_ack0} !== 3'b000 || d_rdata0 !== 16'h0000) begin
            n_fail++;
            $display("FAIL single_done: busy/fack/dack=%b%b%b drdata=%h, required 000 0000",
                     busy0, f_ack0, d_ack0, d_rdata0);
        end
    endtask

    task automatic test_tie();
        int f_cyc = -1;
        int d_cyc = -1;
        do_reset();
        f_req0 = 1'b1; f_addr0 = 16'h0000;
        d_req0 = 1'b1; d_addr0 = 16'h000F;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (f_ack0) begin f_cyc = k; f_req0 = 1'b0; end
            if (d_ack0) begin d_cyc = k; d_req0 = 1'b0; end
        end
        n_checks++;
        if (f_cyc < 0 || d_cyc < 0 || d_cyc - f_cyc != 3) begin
            n_fail++;
            $display("FAIL tie_order: f_ack at %0d d_ack at %0d, required F first and D 3 cycles later",
                     f_cyc, d_cyc);
        end
        n_checks++;
        if (f_rdata0 !== 16'hFFFF || d_rdata0 !== 16'hFFF0) begin
            n_fail++;
            $display("FAIL tie_data: f_rdata=%h d_rdata=%h, required FFFF FFF0", f_rdata0, d_rdata0);
        end
    endtask

    task automatic test_contention();
        logic exp_d = 1'b0;
        int   f_cnt = 0;
        int   d_cnt = 0;
        int   both  = 0;
        int   order_err = 0;
        int   data_err  = 0;
        do_reset();
        f_req0 = 1'b1; f_addr0 = 16'h0010;
        d_req0 = 1'b1; d_addr0 = 16'h0020;
        for (int k = 0; k < 60 && (f_cnt + d_cnt) < 12; k++) begin
            @(negedge clk);
            if (f_ack0 && d_ack0) both++;
            if (f_ack0) begin
                f_cnt++;
                if (exp_d) order_err++;
                if (f_rdata0 !== 16'hFFEF) data_err++;
                exp_d = 1'b1;
            end else if (d_ack0) begin
                d_cnt++;
                if (!exp_d) order_err++;
                if (d_rdata0 !== 16'hFFDF) data_err++;
                exp_d = 1'b0;
            end
        end
        f_req0 = 1'b0; d_req0 = 1'b0;
        n_checks++;
        if (f_cnt != 6 || d_cnt != 6) begin
            n_fail++;
            $display("FAIL contention_count: f=%0d d=%0d acks, required 6 6", f_cnt, d_cnt);
        end
        n_checks++;
        if (order_err != 0 || both != 0) begin
            n_fail++;
            $display("FAIL contention_order: %0d out-of-order acks, %0d double-ack cycles, required 0 0",
                     order_err, both);
        end
        n_checks++;
        if (data_err != 0) begin
            n_fail++;
            $display("FAIL contention_data: %0d wrong rdata values, required 0", data_err);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wait_states();
        int en_cnt = 0;
        int ack_k  = -1;
        int f_seen = 0;
        do_reset();
        d_req3 = 1'b1; d_addr3 = 16'h0001;
        @(posedge clk);   // grant edge
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rom_en3 && rom_addr3 == 16'h0001) en_cnt++;
            if (f_ack3) f_seen++;
            if (d_ack3) begin ack_k = k; d_req3 = 1'b0; end
        end
        n_checks++;
        if (en_cnt != 4) begin
            n_fail++;
            $display("FAIL wait_enable: rom_en high %0d cycles, required 4", en_cnt);
        end
        n_checks++;
        if (ack_k != 5 || f_seen != 0) begin
            n_fail++;
            $display("FAIL wait_ack: d_ack %0d cycles after grant, f_ack seen %0d, required 5 0",
                     ack_k, f_seen);
        end
        n_checks++;
        if (d_rdata3 !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL wait_data: d_rdata=%h, required FFFE", d_rdata3);
        end
    endtask

    task automatic test_reset_mid_access();
        int got = 0;
        int acks = 0;
        int first = -1;   // 0 = F, 1 = D
        do_reset();
        // Complete one fetch so the arbiter has last_grant = F before the abort.
        f_req3 = 1'b1; f_addr3 = 16'h0007;
        for (int k = 0; k < 12 && got == 0; k++) begin
            @(negedge clk);
            if (f_ack3) begin got = 1; f_req3 = 1'b0; end
        end
        n_checks++;
        if (got != 1 || f_rdata3 !== 16'hFFF8) begin
            n_fail++;
            $display("FAIL abort_setup: ack seen=%0d f_rdata=%h, required 1 FFF8", got, f_rdata3);
        end
        @(negedge clk);
        d_req3 = 1'b1; d_addr3 = 16'h0009;
        got = 0;
        for (int k = 0; k < 6 && got == 0; k++) begin
            @(negedge clk);
            if (rom_en3) got = 1;   // first ACCESS cycle
        end
        @(posedge clk);
        #1 rst3 = 1'b1;             // asserted during the second ACCESS cycle
        d_req3 = 1'b0;
        @(posedge clk);
        #1 rst3 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (got != 1 || rom_en3 !== 1'b0 || busy3 !== 1'b0 || state3 !== 2'd0) begin
            n_fail++;
            $display("FAIL abort_state: access seen=%0d en=%b busy=%b st=%0d, required 1 0 0 0",
                     got, rom_en3, busy3, state3);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (f_ack3 || d_ack3) acks++;
        end
        n_checks++;
        if (acks != 0 || f_rdata3 !== 16'h0 || d_rdata3 !== 16'h0) begin
            n_fail++;
            $display("FAIL abort_noack: %0d acks f_rdata=%h d_rdata=%h, required 0 0000 0000",
                     acks, f_rdata3, d_rdata3);
        end
        f_req3 = 1'b1; f_addr3 = 16'h0004;
        d_req3 = 1'b1; d_addr3 = 16'h0008;
        for (int k = 0; k < 12 && first < 0; k++) begin
            @(negedge clk);
            if (f_ack3) first = 0;
            else if (d_ack3) first = 1;
        end
        f_req3 = 1'b0; d_req3 = 1'b0;
        n_checks++;
        if (first != 0 || f_rdata3 !== 16'hFFFB) begin
            n_fail++;
            $display("FAIL abort_tie: first grant=%0d (0=F,1=D,-1=none) f_rdata=%h, required 0 FFFB",
                     first, f_rdata3);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_addr_stability();
        int bad_addr = 0;
        int got = 0;
        do_reset();
        f_req0 = 1'b1; f_addr0 = 16'h0002;
        @(posedge clk);   // grant edge
        #1 f_addr0 = 16'h0003;
        for (int k = 0; k < 6 && got == 0; k++) begin
            @(negedge clk);
            if (rom_en0 && rom_addr0 !== 16'h0002) bad_addr++;
            if (f_ack0) begin got = 1; f_req0 = 1'b0; end
        end
        n_checks++;
        if (got != 1 || bad_addr != 0 || f_rdata0 !== 16'hFFFD) begin
            n_fail++;
            $display("FAIL addr_stable: ack=%0d bad addr cycles=%0d f_rdata=%h, required 1 0 FFFD",
                     got, bad_addr, f_rdata0);
        end
        @(negedge clk);
        n_checks++;
        if (rom_addr0 !== 16'h0002 || rom_en0 !== 1'b0) begin
            n_fail++;
            $display("FAIL addr_retain: rom_addr=%h en=%b, required 0002 0", rom_addr0, rom_en0);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_tie();
        test_contention();
        test_wait_states();
        test_reset_mid_access();
        test_addr_stability();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
